// File: rtl/alu_arbiter_if.sv
// Bundle between two ALU requesters, the arbiter and the shared combinational ALU.
// The slave modport is the arbiter's view. The master modport is the view of the requesters and the ALU.
interface alu_arbiter_if #(
  parameter int DW  = 8,
  parameter int OPW = 5
);
  logic           req0, req1;
  logic [OPW-1:0] op0, op1;
  logic [DW-1:0]  a0, b0, a1, b1;
  logic           ci0, ci1;
  logic           gnt0, gnt1;
  logic [OPW-1:0] alu_op;
  logic [DW-1:0]  alu_a, alu_b;
  logic           alu_ci;
  logic [DW-1:0]  alu_rslt;
  logic           alu_co, alu_equal, alu_gt, alu_lt, alu_zero;
  logic           rsp_valid0, rsp_valid1;
  logic [DW-1:0]  rsp_rslt;
  logic           rsp_co, rsp_equal, rsp_gt, rsp_lt, rsp_zero;
  logic           busy;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, ci0, ci1,
    input  alu_rslt, alu_co, alu_equal, alu_gt, alu_lt, alu_zero,
    output gnt0, gnt1, alu_op, alu_a, alu_b, alu_ci,
    output rsp_valid0, rsp_valid1, rsp_rslt, rsp_co, rsp_equal, rsp_gt, rsp_lt, rsp_zero,
    output busy
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, ci0, ci1,
    output alu_rslt, alu_co, alu_equal, alu_gt, alu_lt, alu_zero,
    input  gnt0, gnt1, alu_op, alu_a, alu_b, alu_ci,
    input  rsp_valid0, rsp_valid1, rsp_rslt, rsp_co, rsp_equal, rsp_gt, rsp_lt, rsp_zero,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// An operation takes three cycles: grant in IDLE, evaluate in EXEC, respond in DONE.
// state | meaning
// IDLE  | wait for a request; grant the winner and capture its operands
// EXEC  | operand registers drive the ALU; its outputs are latched at the edge
// DONE  | one-cycle rsp_valid pulse to the captured winner
module alu_arbiter #(
  parameter int DW  = 8,
  parameter int OPW = 5
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t         r_state, w_next;
  logic           r_ptr, r_win;
  logic           w_any, w_win, w_grant;
  logic [OPW-1:0] r_op;
  logic [DW-1:0]  r_a, r_b, r_rslt;
  logic           r_ci, r_co, r_equal, r_gt, r_lt, r_zero;

  assign w_any   = bus.req0 | bus.req1;
  // On a tie the pointer decides; otherwise the only requester present wins.
  assign w_win   = (bus.req0 & bus.req1) ? r_ptr : bus.req1;
  assign w_grant = (r_state == IDLE) & w_any;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = EXEC;
      EXEC:    w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // The reset term keeps the grants low while reset is held, even with requests present.
  always_comb begin
    bus.gnt0       = 1'b0;
    bus.gnt1       = 1'b0;
    bus.rsp_valid0 = 1'b0;
    bus.rsp_valid1 = 1'b0;
    bus.busy       = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        bus.gnt0 = reset & w_any & ~w_win;
        bus.gnt1 = reset & w_any & w_win;
      end
      DONE: begin
        bus.rsp_valid0 = ~r_win;
        bus.rsp_valid1 = r_win;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= 1'b0;
      r_win <= 1'b0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_ci  <= 1'b0;
    end else if (w_grant) begin
      r_ptr <= ~w_win;
      r_win <= w_win;
      r_op  <= w_win ? bus.op1 : bus.op0;
      r_a   <= w_win ? bus.a1  : bus.a0;
      r_b   <= w_win ? bus.b1  : bus.b0;
      r_ci  <= w_win ? bus.ci1 : bus.ci0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rslt  <= '0;
      r_co    <= 1'b0;
      r_equal <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_zero  <= 1'b0;
    end else if (r_state == EXEC) begin
      r_rslt  <= bus.alu_rslt;
      r_co    <= bus.alu_co;
      r_equal <= bus.alu_equal;
      r_gt    <= bus.alu_gt;
      r_lt    <= bus.alu_lt;
      r_zero  <= bus.alu_zero;
    end
  end

  // The ALU is always driven from the registers, so requester inputs never reach it directly.
  assign bus.alu_op    = r_op;
  assign bus.alu_a     = r_a;
  assign bus.alu_b     = r_b;
  assign bus.alu_ci    = r_ci;
  assign bus.rsp_rslt  = r_rslt;
  assign bus.rsp_co    = r_co;
  assign bus.rsp_equal = r_equal;
  assign bus.rsp_gt    = r_gt;
  assign bus.rsp_lt    = r_lt;
  assign bus.rsp_zero  = r_zero;
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DW, default 8, operand/result width in bits.
REQ-002 Parameter OPW, default 5, ALUOp width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, independent of clk.
REQ-005 req0, req1  input  1 each  requester 0/1 operation request; held high until the matching gnt is seen.
REQ-006 op0, op1  input  OPW each  requested ALUOp code; valid while req high.
REQ-007 a0, b0, a1, b1  input  DW each  requested operands A/B.
REQ-008 ci0, ci1  input  1 each  requested carry-in.
REQ-009 gnt0, gnt1  output  1 each  grant pulse; operands of that requester are captured on this cycle's rising edge.
REQ-010 alu_op  output  OPW, alu_a/alu_b  output  DW, alu_ci  output  1: drive to the shared ALU.
REQ-011 alu_rslt  input  DW, alu_co, alu_equal, alu_gt, alu_lt, alu_zero  input  1 each: combinational ALU outputs.
REQ-012 rsp_valid0, rsp_valid1  output  1 each  one-cycle result-valid pulse to requester 0/1.
REQ-013 rsp_rslt  output  DW, rsp_co, rsp_equal, rsp_gt, rsp_lt, rsp_zero  output  1 each: registered result and flags, shared by both requesters.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, EXEC, DONE; exactly one active; encoding free.
REQ-016 IDLE: no req -> stay IDLE, no gnt; any req -> assert winner's gnt combinationally this cycle, capture winner's op/a/b/ci into operand registers and winner ID at the edge, go EXEC.
REQ-017 Arbitration: single req -> that requester wins; both req -> requester named by round-robin pointer wins.
REQ-018 Pointer update only on a grant: pointer <= the non-winning requester; no grant -> pointer unchanged.
REQ-019 gnt0 and gnt1 never high in the same cycle; gnt high only in IDLE.
REQ-020 EXEC: alu_op/alu_a/alu_b/alu_ci driven from operand registers; at the edge, alu_rslt, alu_co and four flags latched into rsp_* registers; go DONE.
REQ-021 Outside EXEC, alu_op/alu_a/alu_b/alu_ci hold last captured operand values (no glitching to requester inputs).
REQ-022 DONE: rsp_valid of captured winner high for exactly this cycle, other rsp_valid low; go IDLE next edge.
REQ-023 rsp_* result/flag registers hold value until next EXEC completes.
REQ-024 Latency: gnt in cycle N -> ALU evaluated cycle N+1 -> rsp_valid cycle N+2; max throughput one op per 3 cycles.
REQ-025 req changes, or new req, during EXEC/DONE ignored; requester whose req is still high after its DONE is re-arbitrated in next IDLE.
REQ-026 A requester granted still holding req in next IDLE while other also requests loses (pointer moved); no requester starved beyond one op.
REQ-027 No interpretation of op codes; arbiter is opcode-agnostic and passes OPW bits unchanged.

Reset
REQ-028 reset low: state IDLE, pointer = requester 0, operand registers 0, winner ID 0, rsp_rslt 0, all rsp flags 0, rsp_valid0/1 0, busy 0.
REQ-029 gnt0/gnt1 0 while reset low regardless of req.
REQ-030 Reset mid-EXEC or mid-DONE aborts op: no rsp_valid pulse emitted, rsp_* cleared, pointer returns to 0.
REQ-031 First rising edge after reset deassertion behaves as IDLE.

Verification
REQ-032 req0 only, op0=5'b01101, a0=8'h01, b0=8'h04, ci0=0, ALU model adds -> gnt0 cycle N, rsp_valid0 cycle N+2, rsp_rslt=8'h05, rsp_co=0, rsp_zero=0.
REQ-033 req0 and req1 both high from reset, held continuously -> grant order gnt0, gnt1, gnt0, gnt1 every 3 cycles; rsp_valid pulses match order.
REQ-034 req1 only, op1=5'b00101 (compare), a1=8'h71, b1=8'h70 -> rsp_valid1 pulse, rsp_gt=1, rsp_equal=0, rsp_lt=0; rsp_valid0 stays 0.
REQ-035 req0 granted, reset low during EXEC for half cycle -> no rsp_valid, all rsp_* 0, busy 0; next req1 with req0 both high -> gnt0 first.
REQ-036 req1 raised during EXEC of requester 0 op, a0 changed during EXEC -> rsp_rslt reflects captured a0; gnt1 in next IDLE; gnt0/gnt1 never simultaneous (assertion across all tests).
